// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: register map, frame geometry and receiver state encoding
// shared by the SPI receiver, the PWM block and the top-level wrapper.
`default_nettype none

package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    EVAL   = 2'd2
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input, followed by
// a history flop that yields single-cycle rise/fall events.
`default_nettype none

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Clearing to 0 means a low input at reset release never looks like a
  // falling edge, so a frame already in progress cannot be joined.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

`default_nettype wire

// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI mode-0 slave holding the five PWM
// configuration registers; commits a 16-bit frame when chip select rises.
`default_nettype none

module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

  spi_state_t  state, next_state;
  logic [15:0] shift;
  logic [4:0]  count;
  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        commit;

  assign frame_addr = shift[14:8];
  assign frame_data = shift[7:0];

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (ncs_rise) begin
          next_state = EVAL;
          commit     = (count == CNT_FULL) && shift[15] && (frame_addr <= MAX_ADDR);
        end
      end
      EVAL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      shift           <= '0;
      count           <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      state     <= next_state;
      wr_strobe <= commit;

      // A clock edge coinciding with the closing chip-select edge is dropped
      // so EVAL judges the frame exactly as it stood before that cycle.
      if (state == ACTIVE) begin
        if (sclk_rise && !ncs_rise) begin
          shift <= {shift[14:0], copi_level};
          if (count != CNT_SAT) count <= count + 5'd1;
        end
      end else begin
        shift <= '0;
        count <= '0;
      end

      if (commit) begin
        case (frame_addr)
          ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= frame_data;
          ADDR_EN_OUT_15_8: en_reg_out_15_8 <= frame_data;
          ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= frame_data;
          ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= frame_data;
          ADDR_PWM_DUTY:    pwm_duty_cycle  <= frame_data;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed self-checking bench for spi_peripheral.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic prev_strobe = 1'b0;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe must never stay high for two consecutive cycles.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      check("strobe_width", {31'd0, prev_strobe}, 32'd0);
    end
    prev_strobe <= (wr_strobe === 1'b1);
  end

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, "_r0"}, {24'd0, en_reg_out_7_0},  {24'd0, e0});
    check({tag, "_r1"}, {24'd0, en_reg_out_15_8}, {24'd0, e1});
    check({tag, "_r2"}, {24'd0, en_reg_pwm_7_0},  {24'd0, e2});
    check({tag, "_r3"}, {24'd0, en_reg_pwm_15_8}, {24'd0, e3});
    check({tag, "_r4"}, {24'd0, pwm_duty_cycle},  {24'd0, e4});
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk) ncs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [16:0] f, input int hi, input int lo, input int half_ns);
    for (int i = hi; i >= lo; i--) begin
      copi = f[i];
      #(half_ns) sclk = 1'b1;
      #(half_ns) sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [16:0] f, input int nbits);
    cs_low();
    shift_bits(f, nbits - 1, 0, 40);
    cs_high();
  endtask

  logic [7:0] model [5];
  int         base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset_strobe", {31'd0, wr_strobe}, 32'd0);

    // Write 0x8055 and check the commit lands exactly on the 3rd edge.
    cs_low();
    shift_bits(17'h08055, 15, 0, 40);
    repeat (3) @(negedge clk);
    ncs = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("lat_edge2_r0", {24'd0, en_reg_out_7_0}, 32'h00);
    check("lat_edge2_strobe", {31'd0, wr_strobe}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_r0", {24'd0, en_reg_out_7_0}, 32'h55);
    check("lat_edge3_strobe", {31'd0, wr_strobe}, 32'd1);
    @(posedge clk); #1;
    check("lat_edge4_strobe", {31'd0, wr_strobe}, 32'd0);
    repeat (4) @(negedge clk);
    check_regs("first_write", 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
    check("first_strobes", strobe_cnt, 1);

    // All addresses, then a one-cycle reset.
    frame(17'h081F0, 16);
    frame(17'h0820F, 16);
    frame(17'h083AA, 16);
    frame(17'h084C0, 16);
    check_regs("all_addr", 8'h55, 8'hF0, 8'h0F, 8'hAA, 8'hC0);
    check("all_addr_strobes", strobe_cnt, 5);
    pulse_rst();
    @(negedge clk);
    check_regs("after_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Read frame, out-of-range address, address 0x7F.
    base = strobe_cnt;
    frame(17'h00412, 16);
    frame(17'h08533, 16);
    frame(17'h0FF77, 16);
    check_regs("rejected", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("rejected_strobes", strobe_cnt - base, 0);

    // Short and long frames, then a valid write.
    frame(17'h04012, 15);
    frame(17'h10412, 17);
    check_regs("length_err", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("length_err_strobes", strobe_cnt - base, 0);
    frame(17'h08499, 16);
    check_regs("after_len", 8'h00, 8'h00, 8'h00, 8'h00, 8'h99);
    check("after_len_strobes", strobe_cnt - base, 1);

    // Reset in the middle of a frame discards it.
    base = strobe_cnt;
    cs_low();
    shift_bits(17'h08466, 15, 8, 40);
    pulse_rst();
    shift_bits(17'h08466, 7, 0, 40);
    cs_high();
    check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("midrst_strobes", strobe_cnt - base, 0);
    frame(17'h08466, 16);
    check_regs("post_midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h66);

    // Minimum sclk phase width with random clk/sclk phase offsets.
    model[0] = 8'h00; model[1] = 8'h00; model[2] = 8'h00; model[3] = 8'h00; model[4] = 8'h66;
    base = strobe_cnt;
    for (int n = 0; n < 100; n++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 4));
      d = 8'($urandom);
      model[a] = d;
      #($urandom_range(0, 9));
      ncs = 1'b0;
      #30;
      shift_bits({1'b0, 1'b1, 4'd0, a, d}, 15, 0, 30);
      #30 ncs = 1'b1;
      #50;
    end
    repeat (6) @(negedge clk);
    check_regs("random", model[0], model[1], model[2], model[3], model[4]);
    check("random_strobes", strobe_cnt - base, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_peripheral.md
# spi_peripheral

- Write-only SPI slave: receives 16-bit transactions from an external controller on three `ui_in` pins.
- Holds the five configuration registers that drive `pwm_peripheral`.
- Sits directly upstream of `pwm_peripheral` inside the top-level wrapper. Its register outputs connect one-to-one to that block's enable and duty-cycle inputs.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer. Minimum 2.

Ports:
- `clk`  input  1  system clock; all state is updated on its rising edge
- `rst`  input  1  reset; one clock, synchronous, active-high
- `sclk`  input  1  SPI clock, asynchronous to `clk`
- `copi`  input  1  controller-out/peripheral-in data, asynchronous
- `ncs`  input  1  chip select, active-low, asynchronous
- `en_reg_out_7_0`  output  8  output-enable bits 7..0, address 0x00
- `en_reg_out_15_8`  output  8  output-enable bits 15..8, address 0x01
- `en_reg_pwm_7_0`  output  8  PWM-enable bits 7..0, address 0x02
- `en_reg_pwm_15_8`  output  8  PWM-enable bits 15..8, address 0x03
- `pwm_duty_cycle`  output  8  duty cycle, address 0x04
- `wr_strobe`  output  1  one-cycle pulse on each accepted write

## Operation

- **SPI mode 0:**
  - MSB first.
  - Data is sampled on the rising edge of `sclk`.
  - The peripheral never drives a data line.
- **Frame format:** bit 15 = R/W (1 = write), bits 14..8 = address, bits 7..0 = data.
- **Input conditioning:**
  - `sclk`, `copi` and `ncs` each pass through a `SYNC_STAGES` synchronizer, followed by one history flop.
  - Edge events are derived only from the synchronized values.
- **States:**
  - IDLE: synchronized `ncs` high. Shift register and bit counter are held at 0.
  - ACTIVE: entered when synchronized `ncs` falls. On each synchronized `sclk` rising edge, shift `copi` into bit 0 and increment the counter.
  - The counter saturates at 17; the value 17 marks an over-length frame.
  - EVAL: entered for one cycle when synchronized `ncs` rises, then returns to IDLE.
- **Commit rule in EVAL:** the write is accepted only if all of the following hold:
  - counter == 16
  - bit 15 == 1
  - address ≤ 0x04
- **Accepted write:** the addressed register loads the data byte and `wr_strobe` = 1 for that cycle.
- **Rejected frames:** no register changes and `wr_strobe` stays 0. This covers:
  - read frames (bit 15 = 0)
  - addresses 0x05..0x7F
  - short frames (< 16 bits)
  - long frames (> 16 bits)
- **Output hold:** registers keep their value until the next accepted write to the same address. Outputs are direct register outputs, not combinational.
- **Reset values:** `rst` high forces all five registers to 0x00, `wr_strobe` to 0, counter and shift register to 0, and state to IDLE.
- **Reset mid-frame:** the partial frame is discarded. The peripheral remains in IDLE until synchronized `ncs` is seen high, then low again, so a frame already in progress is never resumed.
- **Simultaneous events:** if a synchronized `sclk` rise and a synchronized `ncs` rise occur in the same cycle, the `sclk` edge is ignored and EVAL uses the counter value from before that cycle.

## Timing

- **Write latency** with `SYNC_STAGES` = 2: registers and `wr_strobe` update at the 3rd `clk` rising edge after `ncs` rises, given that `ncs` meets setup to `clk`. In general the latency is `SYNC_STAGES` + 1 edges.
- **Input requirements:**
  - `sclk` high and low phases each ≥ `SYNC_STAGES` + 1 `clk` periods. With a 50 MHz `clk` and the default depth, this allows `sclk` up to about 8 MHz.
  - `copi` stable from ≥ 1 `clk` period before to ≥ 1 `clk` period after each `sclk` rise.
  - `ncs` falls ≥ 2 `clk` periods before the first `sclk` rise.
  - `ncs` rises ≥ 2 `clk` periods after the last `sclk` fall.
  - `ncs` stays high ≥ 2 `clk` periods between frames.
- `wr_strobe` is exactly one `clk` cycle wide per accepted frame.
- Back-to-back accepted frames produce separate strobes.

## Structure

- **Shared package `spi_regs_pkg`:**
  - Address constants: `ADDR_EN_OUT_7_0` = 0x00, `ADDR_EN_OUT_15_8` = 0x01, `ADDR_EN_PWM_7_0` = 0x02, `ADDR_EN_PWM_15_8` = 0x03, `ADDR_PWM_DUTY` = 0x04.
  - `MAX_ADDR` = 0x04.
  - `FRAME_BITS` = 16.
  - State enum: IDLE, ACTIVE, EVAL.
  - `pwm_peripheral` and the top-level wrapper import the same address constants.
- **Sub-module `sync_edge`:** `SYNC_STAGES` synchronizer plus history flop, with outputs `level`, `rise` and `fall`. Instantiated three times, once each for `sclk`, `copi` and `ncs`.

## Test plan

- **Reset:** reset, then write frame 0x8055 (addr 0x00, data 0x55). Expect `en_reg_out_7_0` = 0x55 exactly 3 `clk` edges after `ncs` rises, a single `wr_strobe` pulse, and all other registers still 0x00.
- **All addresses:** write 0x81F0, 0x820F, 0x83AA and 0x84C0. Expect registers 0x01–0x04 = 0xF0, 0x0F, 0xAA, 0xC0 and four strobes. Then assert `rst` for one cycle and expect all five registers = 0x00.
- **Rejected frames:** send read frame 0x0412, out-of-range write 0x8533, and write 0xFF77 (addr 0x7F). Expect no register changes and no strobe.
- **Length errors:** send 15-bit frame 0x4012 and 17-bit frame 0x1_0412. Expect registers unchanged and `wr_strobe` never asserted. Then send a valid 0x8499 and expect `pwm_duty_cycle` = 0x99.
- **Reset mid-frame:** after 8 bits of 0x8466, assert `rst` for one cycle, finish the frame, then raise `ncs`. Expect `pwm_duty_cycle` = 0x00. A following full 0x8466 frame gives 0x66.
- **Timing corners:** run at minimum `sclk` phase width (3 `clk` periods) with random `clk`/`sclk` phase offsets and 100 random valid writes. Every register must match a software model and the strobe count must equal 100.
